// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 pixel-frame sequencer with pixel store and frame timing
//
// Holds a NUM_LEDS-deep GRB pixel store and hands one word to the bit
// serialiser per tx_done. Refreshes are framed by a data_ready window of
// FRAME_CYCLES followed by a low gap of GAP_CYCLES (latch reset).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tx_done      serialiser requests next word (1-cycle pulse)
//   mode         0 stored, 1 solid, 2 chase, 3 blank (sampled at frame start)
//   solid_color  colour used in solid mode
//   wr_en/wr_addr/wr_data  pixel store write port (out-of-range addresses dropped)
//   data_ready   high during the frame window
//   data_valid   high once the last pixel of the frame has been presented
//   RGB          current pixel word
//   frame_done   1-cycle pulse at the end of each frame window

module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 5,
    parameter int START_DELAY  = 1000,
    parameter int FRAME_CYCLES = 39000,
    parameter int GAP_CYCLES   = 5000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_done,
    input  logic [1:0]                  mode,
    input  logic [23:0]                 solid_color,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [23:0]                 wr_data,
    output logic                        data_ready,
    output logic                        data_valid,
    output logic [23:0]                 RGB,
    output logic                        frame_done
);

    localparam int AW = $clog2(NUM_LEDS);
    // idx must be able to reach NUM_LEDS (frame exhausted)
    localparam int IW = $clog2(NUM_LEDS + 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     cnt;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   offset;
    logic [1:0]      mode_q;
    logic [23:0]     mem [NUM_LEDS];

    logic            wait_done;
    logic            send_done;
    logic            gap_done;
    logic            load;
    logic [AW-1:0]   idx_lo;
    logic [AW:0]     rot_sum;
    logic [AW:0]     rot_wrap;
    logic [AW-1:0]   rd_addr;
    logic [23:0]     pix;

    assign wait_done = (state == ST_WAIT) && (cnt == 32'(START_DELAY - 1));
    assign send_done = (state == ST_SEND) && (cnt == 32'(FRAME_CYCLES - 1));
    assign gap_done  = (state == ST_GAP)  && (cnt == 32'(GAP_CYCLES - 1));

    // Frame expiry has priority over a coincident tx_done.
    assign load = (state == ST_SEND) && tx_done && !send_done && (idx < IW'(NUM_LEDS));

    // Chase address: idx+offset folded back into range with one subtract,
    // valid because both operands are below NUM_LEDS.
    assign idx_lo   = idx[AW-1:0];
    assign rot_sum  = {1'b0, idx_lo} + {1'b0, offset};
    assign rot_wrap = (rot_sum >= (AW+1)'(NUM_LEDS)) ? (rot_sum - (AW+1)'(NUM_LEDS)) : rot_sum;
    assign rd_addr  = (mode_q == 2'd2) ? rot_wrap[AW-1:0] : idx_lo;

    always_comb begin
        pix = 24'h000000;
        case (mode_q)
            2'd0:    pix = mem[rd_addr];
            2'd1:    pix = solid_color;
            2'd2:    pix = mem[rd_addr];
            default: pix = 24'h000000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (wait_done) state_nxt = ST_SEND;
            ST_SEND: if (send_done) state_nxt = ST_GAP;
            ST_GAP:  if (gap_done)  state_nxt = ST_SEND;
            default: state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 32'd0;
            data_ready <= 1'b0;
            data_valid <= 1'b0;
            RGB        <= 24'h000000;
            frame_done <= 1'b0;
            idx        <= '0;
            offset     <= '0;
            mode_q     <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            cnt        <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;

            if (wait_done || gap_done) begin
                data_ready <= 1'b1;
                mode_q     <= mode;
            end

            if (send_done) begin
                data_ready <= 1'b0;
                data_valid <= 1'b0;
                RGB        <= 24'h000000;
                idx        <= '0;
                frame_done <= 1'b1;
                if (mode_q == 2'd2) begin
                    offset <= (offset == AW'(NUM_LEDS - 1)) ? '0 : offset + AW'(1);
                end
            end else if (load) begin
                RGB <= pix;
                idx <= idx + IW'(1);
                if (idx == IW'(NUM_LEDS - 1)) begin
                    data_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mem[i] <= 24'h000000;
            end
        end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_LEDS))) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/ws2812_frame_ctrl.md
# ws2812_frame_ctrl

Parametrised pixel-frame sequencer for a WS2812 LED chain. It sits between host logic and the WS2812 bit-serialiser. It holds an NUM_LEDS-deep 24-bit pixel store and presents one GRB word per serialiser `tx_done`. It frames each refresh with a ready window and a reset gap. Frame content is selected by a mode input: stored pattern, solid colour, rotating chase, or blank.

## Interface
- NUM_LEDS, 5, pixels per frame (≥2)
- START_DELAY, 1000, clk cycles from reset release to first frame
- FRAME_CYCLES, 39000, clk cycles data_ready stays high per frame
- GAP_CYCLES, 5000, clk cycles data_ready stays low between frames (latch reset gap)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_done  in  1  serialiser finished current word / requests next (1-cycle pulse)
- mode  in  2  0 stored, 1 solid, 2 chase, 3 blank
- solid_color  in  24  colour used in mode 1
- wr_en  in  1  pixel store write strobe
- wr_addr  in  $clog2(NUM_LEDS)  pixel store address; ≥NUM_LEDS ignored
- wr_data  in  24  pixel store write data
- data_ready  out  1  high during frame window; serialiser runs only while high
- data_valid  out  1  high once last pixel of frame has been loaded onto RGB
- RGB  out  24  current pixel word to serialiser
- frame_done  out  1  1-cycle pulse at end of each frame window

## Operation
- FSM states: WAIT, SEND, GAP. One shared cycle counter `cnt`, cleared on every state change.
- Reset (async): state WAIT, cnt 0, data_ready 0, data_valid 0, RGB 0, frame_done 0, idx 0, offset 0, mode_q 0, all pixel store entries 0.
- WAIT: when cnt == START_DELAY-1, go to SEND, data_ready←1, mode_q←mode.
- SEND: on tx_done with idx < NUM_LEDS: RGB←pix(idx), idx←idx+1. If idx == NUM_LEDS-1, also data_valid←1. tx_done with idx == NUM_LEDS is ignored; RGB and data_valid hold.
- SEND: when cnt == FRAME_CYCLES-1, go to GAP. Set data_ready←0, data_valid←0, RGB←0, idx←0, frame_done←1 for one cycle. If mode_q == 2: offset←(offset+1) mod NUM_LEDS.
- GAP: when cnt == GAP_CYCLES-1, go to SEND, data_ready←1, mode_q←mode.
- pix(i) by mode_q:
  - 0: mem[i]
  - 1: solid_color
  - 2: mem[(i+offset) mod NUM_LEDS] (add then conditional subtract; no divider)
  - 3: 24'h000000
- mode is sampled only at SEND entry; mode changes mid-frame take effect next frame. offset keeps its value while mode ≠ 2.
- Pixel store: synchronous write on wr_en, accepted in any state. Read is combinational from the register array.

## Timing
- tx_done sampled at cycle N → RGB/idx/data_valid updated visible at N+1.
- First data_ready rise: START_DELAY cycles after reset release. Period thereafter = FRAME_CYCLES + GAP_CYCLES.
- data_ready falls on the same edge frame_done rises.
- tx_done coincident with SEND expiry: expiry wins, word not loaded.
- tx_done during WAIT/GAP: ignored.
- Write and read of same address in same cycle: read returns old value; new value seen from next read.
- rst_n asserted mid-frame: all outputs to reset values immediately (async). Sequence restarts from WAIT.
- data_valid rises on the edge after the NUM_LEDS-th tx_done of the frame and stays high until the frame end.

## Test plan
- Reset release, defaults, no tx_done → data_ready rises at cycle 1000, falls at 40000 with a frame_done pulse, rises again at 45000. RGB stays 0.
- Mode 0, mem = {FF00FF,00FF00,AA55AA,A543D5,123456}, 5 tx_done pulses spaced 30 cycles → RGB sequence matches mem[0..4] one cycle after each pulse. data_valid rises after the 5th pulse. A 6th pulse leaves RGB = 123456.
- Mode 2, same mem, three frames → first word per frame: FF00FF, 00FF00, AA55AA. Frame 2 wraps so the last word is mem[0] = FF00FF.
- Mode 1 with solid_color = 0F0F0F, mode switched to 3 mid-frame → current frame all 0F0F0F; next frame all 000000.
- wr_en to addr 2 with 7E7E7E in the same cycle tx_done reads idx 2 → RGB = AA55AA; next frame idx 2 → 7E7E7E. wr_addr 7 (NUM_LEDS=5) → no store change.
- rst_n pulsed low after 3rd tx_done → data_ready, data_valid, RGB immediately 0. Next data_ready rise is 1000 cycles after release.
